// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath: default bus widths and the ALU
// operation codes produced by ALU control and consumed by the execute stage.
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int NB_DATA    = 32;
    localparam int NB_OPE     = 5;
    localparam int NB_REG     = 5;
    localparam int NB_MEM_CTL = 4;
    localparam int NB_WB_CTL  = 2;

    localparam logic [NB_OPE-1:0] ALU_AND = 5'd0;
    localparam logic [NB_OPE-1:0] ALU_OR  = 5'd1;
    localparam logic [NB_OPE-1:0] ALU_ADD = 5'd2;
    localparam logic [NB_OPE-1:0] ALU_XOR = 5'd3;
    localparam logic [NB_OPE-1:0] ALU_SUB = 5'd6;
    localparam logic [NB_OPE-1:0] ALU_SLT = 5'd7;
    localparam logic [NB_OPE-1:0] ALU_SLL = 5'd8;
    localparam logic [NB_OPE-1:0] ALU_SRL = 5'd9;
    localparam logic [NB_OPE-1:0] ALU_SRA = 5'd10;
    localparam logic [NB_OPE-1:0] ALU_NOR = 5'd12;
    localparam logic [NB_OPE-1:0] ALU_JAL = 5'd13;
    localparam logic [NB_OPE-1:0] ALU_LUI = 5'd14;

endpackage

// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU. Arithmetic wraps modulo 2^NB_DATA.
// Ports:
//   i_ope     operation code (mips_pkg ALU_*)
//   i_a       operand A
//   i_b       operand B / operand being shifted
//   i_sa      shift amount
//   o_result  computed result; 0 for JAL (muxed in by the caller) and for
//             unassigned codes
// ----------------------------------------------------------------------------
module alu_core
    import mips_pkg::*;
#(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_SA   = mips_pkg::NB_REG
) (
    input  logic        [NB_OPE-1:0]  i_ope,
    input  logic signed [NB_DATA-1:0] i_a,
    input  logic signed [NB_DATA-1:0] i_b,
    input  logic        [NB_SA-1:0]   i_sa,
    output logic signed [NB_DATA-1:0] o_result
);

    logic slt_w;

    // Both operands are declared signed, so this is a true signed compare
    // rather than the sign of a (possibly overflowing) subtraction.
    assign slt_w = (i_a < i_b);

    always_comb begin
        o_result = '0;
        case (i_ope)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(NB_DATA-1){1'b0}}, slt_w};
            ALU_SLL: o_result = i_b << i_sa;
            ALU_SRL: o_result = $signed($unsigned(i_b) >> i_sa);
            ALU_SRA: o_result = i_b >>> i_sa;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_LUI: o_result = i_b << 16;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// ----------------------------------------------------------------------------
// alu_ex_stage
// Execute stage: computes the ALU result from ID/EX operands and registers it,
// together with destination register and MEM/WB control, into EX/MEM.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              0 freezes all state (debug single-step)
//   i_stall / i_flush     hold / bubble the EX/MEM register
//   i_valid               ID/EX slot carries a real instruction
//   i_alu_ope             ALU operation code
//   i_data_a, i_data_b    operands (B is the shifted operand / store data)
//   i_shamt, i_shift_var  shift amount source select
//   i_link_addr           return address for JAL/JALR
//   i_rd_addr, i_mem_ctl, i_wb_ctl   passed-through destination/control
//   o_*                   registered EX/MEM contents
// Update priority per edge: reset > !enable > flush > stall > load.
// ----------------------------------------------------------------------------
module alu_ex_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA    = mips_pkg::NB_DATA,
    parameter int NB_REG     = mips_pkg::NB_REG,
    parameter int NB_MEM_CTL = mips_pkg::NB_MEM_CTL,
    parameter int NB_WB_CTL  = mips_pkg::NB_WB_CTL
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [NB_OPE-1:0]     i_alu_ope,
    input  logic [NB_DATA-1:0]    i_data_a,
    input  logic [NB_DATA-1:0]    i_data_b,
    input  logic [NB_REG-1:0]     i_shamt,
    input  logic                  i_shift_var,
    input  logic [NB_DATA-1:0]    i_link_addr,
    input  logic [NB_REG-1:0]     i_rd_addr,
    input  logic [NB_MEM_CTL-1:0] i_mem_ctl,
    input  logic [NB_WB_CTL-1:0]  i_wb_ctl,
    output logic                  o_valid,
    output logic [NB_DATA-1:0]    o_result,
    output logic                  o_zero,
    output logic [NB_DATA-1:0]    o_store_data,
    output logic [NB_REG-1:0]     o_rd_addr,
    output logic [NB_MEM_CTL-1:0] o_mem_ctl,
    output logic [NB_WB_CTL-1:0]  o_wb_ctl
);

    logic        [NB_REG-1:0]  sa_w;
    logic signed [NB_DATA-1:0] core_res_w;
    logic signed [NB_DATA-1:0] result_w;

    logic                  valid_q,  valid_d;
    logic [NB_DATA-1:0]    result_q, result_d;
    logic                  zero_q,   zero_d;
    logic [NB_DATA-1:0]    store_q,  store_d;
    logic [NB_REG-1:0]     rd_q,     rd_d;
    logic [NB_MEM_CTL-1:0] mem_q,    mem_d;
    logic [NB_WB_CTL-1:0]  wb_q,     wb_d;

    // Variable shifts (SLLV/SRLV/SRAV) take the amount from rs.
    assign sa_w = i_shift_var ? i_data_a[NB_REG-1:0] : i_shamt;

    alu_core #(
        .NB_DATA (NB_DATA),
        .NB_SA   (NB_REG)
    ) u_alu_core (
        .i_ope    (i_alu_ope),
        .i_a      ($signed(i_data_a)),
        .i_b      ($signed(i_data_b)),
        .i_sa     (sa_w),
        .o_result (core_res_w)
    );

    // The link address is not an ALU operand, so JAL is selected here.
    assign result_w = (i_alu_ope == ALU_JAL) ? $signed(i_link_addr) : core_res_w;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        store_d  = store_q;
        rd_d     = rd_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        if (!i_enable || (i_stall && !i_flush)) begin
            // hold everything
        end else if (i_flush || !i_valid) begin
            // Bubble: o_zero is forced low, not derived from the zero result.
            valid_d  = 1'b0;
            result_d = '0;
            zero_d   = 1'b0;
            store_d  = '0;
            rd_d     = '0;
            mem_d    = '0;
            wb_d     = '0;
        end else begin
            valid_d  = 1'b1;
            result_d = result_w;
            zero_d   = (result_w == '0);
            store_d  = i_data_b;
            rd_d     = i_rd_addr;
            mem_d    = i_mem_ctl;
            wb_d     = i_wb_ctl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            store_q  <= '0;
            rd_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_result     = result_q;
    assign o_zero       = zero_q;
    assign o_store_data = store_q;
    assign o_rd_addr    = rd_q;
    assign o_mem_ctl    = mem_q;
    assign o_wb_ctl     = wb_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
module tb_alu_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] r;
        logic        z;
        logic [4:0]  rd;
        logic [3:0]  mem;
        logic [1:0]  wb;
    } exp_t;

    typedef struct {
        logic [4:0]  ope;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        sv;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, enable, stall, flush, valid;
    logic [4:0]  ope;
    logic [31:0] da, db, link;
    logic [4:0]  shamt, rd;
    logic        svar;
    logic [3:0]  mem;
    logic [1:0]  wb;

    logic        o_valid, o_zero;
    logic [31:0] o_result, o_store_data;
    logic [4:0]  o_rd_addr;
    logic [3:0]  o_mem_ctl;
    logic [1:0]  o_wb_ctl;

    exp_t sb[$];
    exp_t cur;
    exp_t e;
    exp_t got;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_ex_stage dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_valid      (valid),
        .i_alu_ope    (ope),
        .i_data_a     (da),
        .i_data_b     (db),
        .i_shamt      (shamt),
        .i_shift_var  (svar),
        .i_link_addr  (link),
        .i_rd_addr    (rd),
        .i_mem_ctl    (mem),
        .i_wb_ctl     (wb),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_store_data (o_store_data),
        .o_rd_addr    (o_rd_addr),
        .o_mem_ctl    (o_mem_ctl),
        .o_wb_ctl     (o_wb_ctl)
    );

    assign got = {o_valid, o_result, o_zero, o_rd_addr, o_mem_ctl, o_wb_ctl};

    // Reference ALU written straight from the operation table.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa,
                                            input logic [31:0] lk);
        case (op)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a + b;
            5'd3:  return a ^ b;
            5'd6:  return a - b;
            5'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd8:  return b << sa;
            5'd9:  return b >> sa;
            5'd10: return $unsigned($signed(b) >>> sa);
            5'd12: return ~(a | b);
            5'd13: return lk;
            5'd14: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    // Next EX/MEM contents given the current register and the driven inputs.
    function automatic exp_t model_next(input exp_t c);
        exp_t n;
        logic [31:0] r;
        n = c;
        if (rst) n = '0;
        else if (!enable) n = c;
        else if (flush) n = '0;
        else if (stall) n = c;
        else if (!valid) n = '0;
        else begin
            r = ref_alu(ope, da, db, svar ? da[4:0] : shamt, link);
            n = '{v: 1'b1, r: r, z: (r == 32'd0), rd: rd, mem: mem, wb: wb};
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push();
        cur = model_next(cur);
        sb.push_back(cur);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1;
        ope = 5'd2; da = 32'd9; db = 32'd9; shamt = 5'd0; svar = 1'b0;
        link = 32'h40; rd = 5'd3; mem = 4'hF; wb = 2'h3;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('0);
            cur = '0;
            tick();
            e = sb.pop_front();
            n_chk++;
            if (got !== e || o_store_data !== 32'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h store %h expected %h store 0", i, got, o_store_data, e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_directed();
        vec_t t[18];
        t[0]  = '{5'd2,  32'd5,        32'd7,        5'd0,  1'b0, 32'd12};
        t[1]  = '{5'd6,  32'd3,        32'd3,        5'd0,  1'b0, 32'd0};
        t[2]  = '{5'd7,  32'hFFFFFFFF, 32'd1,        5'd0,  1'b0, 32'd1};
        t[3]  = '{5'd7,  32'h80000000, 32'h7FFFFFFF, 5'd0,  1'b0, 32'd1};
        t[4]  = '{5'd7,  32'd1,        32'hFFFFFFFF, 5'd0,  1'b0, 32'd0};
        t[5]  = '{5'd10, 32'd0,        32'h80000000, 5'd4,  1'b0, 32'hF8000000};
        t[6]  = '{5'd8,  32'd33,       32'd1,        5'd7,  1'b1, 32'd2};
        t[7]  = '{5'd9,  32'd0,        32'h80000000, 5'd31, 1'b0, 32'd1};
        t[8]  = '{5'd8,  32'd0,        32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
        t[9]  = '{5'd0,  32'h0000F0F0, 32'h0000FF00, 5'd0,  1'b0, 32'h0000F000};
        t[10] = '{5'd1,  32'h0000F0F0, 32'h00000F00, 5'd0,  1'b0, 32'h0000FFF0};
        t[11] = '{5'd3,  32'h0000FFFF, 32'h00000F0F, 5'd0,  1'b0, 32'h0000F0F0};
        t[12] = '{5'd12, 32'd0,        32'd0,        5'd0,  1'b0, 32'hFFFFFFFF};
        t[13] = '{5'd14, 32'd0,        32'h00001234, 5'd0,  1'b0, 32'h12340000};
        t[14] = '{5'd15, 32'd5,        32'd7,        5'd0,  1'b0, 32'd0};
        t[15] = '{5'd4,  32'd5,        32'd7,        5'd0,  1'b0, 32'd0};
        t[16] = '{5'd2,  32'hFFFFFFFF, 32'd1,        5'd0,  1'b0, 32'd0};
        t[17] = '{5'd13, 32'd5,        32'd7,        5'd0,  1'b0, 32'h00000040};
        enable = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1; link = 32'h40;
        for (int i = 0; i < 18; i++) begin
            ope = t[i].ope; da = t[i].a; db = t[i].b; shamt = t[i].sh; svar = t[i].sv;
            rd = 5'(i + 1); mem = 4'(i); wb = 2'(i);
            cur = '{v: 1'b1, r: t[i].res, z: (t[i].res == 32'd0), rd: 5'(i + 1), mem: 4'(i), wb: 2'(i)};
            sb.push_back(cur);
            tick();
            e = sb.pop_front();
            n_chk++;
            if (got !== e || o_store_data !== t[i].b) begin
                n_fail++;
                $display("FAIL alu_vec[%0d] op=%0d: got %h store %h expected %h store %h",
                         i, t[i].ope, got, o_store_data, e, t[i].b);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        enable = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 40; i++) begin
            valid = ($urandom_range(0, 7) != 0);
            ope = 5'($urandom_range(0, 31));
            da = $urandom; db = $urandom; shamt = 5'($urandom); svar = 1'($urandom);
            link = $urandom; rd = 5'($urandom); mem = 4'($urandom); wb = 2'($urandom);
            if (i % 9 == 0) db = da;
            drive_push();
            tick();
            e = sb.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d: got %h expected %h", i, ope, got, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        enable = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1;
        ope = 5'd2; da = 32'd1; db = 32'd1; svar = 1'b0; shamt = 5'd0;
        rd = 5'd9; mem = 4'h5; wb = 2'h2;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_result !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_load: got %h expected %h", got, e);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            da = 32'd100 + 32'(i); db = 32'd7; rd = 5'(i); mem = 4'hA; wb = 2'h1;
            drive_push();
            tick();
            e = sb.pop_front();
            n_chk++;
            if (got !== e || o_result !== 32'd2 || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, got, e);
            end
        end
        flush = 1'b1;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || got !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL stall_flush: got %h expected %h", got, e);
        end
        stall = 1'b0; flush = 1'b0; valid = 1'b0; ope = 5'd6; da = 32'd4; db = 32'd4;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_bubble: got %h expected %h", got, e);
        end
    endtask

    task automatic test_enable();
        enable = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b1;
        ope = 5'd3; da = 32'h1234; db = 32'h00FF; svar = 1'b0;
        rd = 5'd17; mem = 4'h3; wb = 2'h1;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL enable_load: got %h expected %h", got, e);
        end
        enable = 1'b0; flush = 1'b1; da = 32'h0; db = 32'h0;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_result !== 32'h000012CB || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_flush_hold: got %h expected %h", got, e);
        end
        flush = 1'b0; stall = 1'b1;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_result !== 32'h000012CB) begin
            n_fail++;
            $display("FAIL enable_stall_hold: got %h expected %h", got, e);
        end
        enable = 1'b1; stall = 1'b0; ope = 5'd2; da = 32'd10; db = 32'd20;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_result !== 32'd30) begin
            n_fail++;
            $display("FAIL enable_resume: got %h expected %h", got, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        enable = 1'b1; stall = 1'b1; flush = 1'b0; valid = 1'b1;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || o_result !== 32'd30) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got %h expected %h", got, e);
        end
        rst = 1'b1;
        drive_push();
        tick();
        e = sb.pop_front();
        n_chk++;
        if (got !== e || got !== exp_t'(0) || o_store_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h store %h expected %h", got, o_store_data, e);
        end
        rst = 1'b0; stall = 1'b0;
    endtask

    initial begin
        cur = '0;
        test_reset();
        test_alu_directed();
        test_back_to_back_random();
        test_stall_flush();
        test_enable();
        test_reset_mid_stall();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
